// File: rtl/w_stream_adapter.sv
// w_stream_adapter: write-domain front end of the async FIFO.
// Takes a valid/ready stream from the producer, holds it in a 2-entry skid
// buffer (head + skid) and presents the head word to the FIFO write-pointer
// logic as w_en / w_data ({last, data}). The FIFO qualifies writes with its
// own registered w_full, so w_en is held while full until the word goes in.
// Also counts completed packets and reports a debug state.
//
// Ports
//   w_clk, w_rst         write clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready   producer stream (s_ready registered)
//   w_full               registered full flag from the FIFO write side
//   w_en, w_data         FIFO write request and {last, data}
//   pkt_cnt              packets fully written (wraps)
//   w_state              00 IDLE, 01 STREAM, 10 STALL
//   stall_cnt            saturating count of edges with w_en & w_full
//
// Build option: define W_STALL_CNT_EN to include the stall counter;
// otherwise stall_cnt is tied to 0.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | buffer empty, nothing presented to the FIFO
// ST_STREAM | head word presented, FIFO accepting
// ST_STALL  | head word presented, FIFO reported full

module w_stream_adapter #(
   parameter int DATA_SIZE      = 8,
   parameter int PKT_CNT_SIZE   = 16,
   parameter int STALL_CNT_SIZE = 16
) (
   input  logic                      w_clk,
   input  logic                      w_rst,
   input  logic                      s_valid,
   input  logic [DATA_SIZE-1:0]      s_data,
   input  logic                      s_last,
   output logic                      s_ready,
   input  logic                      w_full,
   output logic                      w_en,
   output logic [DATA_SIZE:0]        w_data,
   output logic [PKT_CNT_SIZE-1:0]   pkt_cnt,
   output logic [1:0]                w_state,
   output logic [STALL_CNT_SIZE-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_STREAM = 2'b01,
      ST_STALL  = 2'b10
   } state_t;

   state_t state_q, state_nxt;

   logic                 head_vld, head_vld_nxt;
   logic                 skid_vld, skid_vld_nxt;
   logic [DATA_SIZE:0]   head_q, head_nxt;
   logic [DATA_SIZE:0]   skid_q, skid_nxt;
   logic                 s_ready_q;
   logic                 accept;
   logic                 consume;
   logic [DATA_SIZE:0]   in_word;

   assign in_word = {s_last, s_data};
   assign accept  = s_valid & s_ready_q;
   assign consume = head_vld & ~w_full;

   always_comb begin
      head_vld_nxt = head_vld;
      skid_vld_nxt = skid_vld;
      head_nxt     = head_q;
      skid_nxt     = skid_q;
      if (consume) begin
         if (skid_vld) begin
            // skid refills head; an incoming word (not expected while the
            // skid is full) would take the freed skid slot
            head_nxt     = skid_q;
            skid_vld_nxt = accept;
            if (accept) skid_nxt = in_word;
         end else if (accept) begin
            head_nxt = in_word;
         end else begin
            head_vld_nxt = 1'b0;
         end
      end else if (accept) begin
         if (!head_vld) begin
            head_nxt     = in_word;
            head_vld_nxt = 1'b1;
         end else begin
            skid_nxt     = in_word;
            skid_vld_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         head_vld  <= 1'b0;
         skid_vld  <= 1'b0;
         head_q    <= '0;
         skid_q    <= '0;
         s_ready_q <= 1'b0;
         pkt_cnt   <= '0;
      end else begin
         head_vld  <= head_vld_nxt;
         skid_vld  <= skid_vld_nxt;
         head_q    <= head_nxt;
         skid_q    <= skid_nxt;
         s_ready_q <= ~skid_vld_nxt;
         if (consume && head_q[DATA_SIZE]) pkt_cnt <= pkt_cnt + 1'b1;
      end
   end

   assign s_ready = s_ready_q;
   assign w_en    = head_vld;
   assign w_data  = head_q;

`ifdef W_STALL_CNT_EN
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         stall_cnt <= '0;
      end else if (head_vld && w_full && (stall_cnt != {STALL_CNT_SIZE{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt = '0;
`endif

   always_ff @(posedge w_clk) begin
      if (w_rst) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (head_vld_nxt) state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (head_vld && w_full)  state_nxt = ST_STALL;
            else if (!head_vld_nxt)  state_nxt = ST_IDLE;
         end
         ST_STALL: begin
            if (consume) state_nxt = head_vld_nxt ? ST_STREAM : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign w_state = state_q;

endmodule

// File: tb/tb_w_stream_adapter.sv
module tb_w_stream_adapter;

   localparam int DW    = 8;
   localparam int PKT_W = 8;
   localparam int STL_W = 16;

   logic             w_clk;
   logic             w_rst;
   logic             s_valid;
   logic [DW-1:0]    s_data;
   logic             s_last;
   logic             s_ready;
   logic             w_full;
   logic             w_en;
   logic [DW:0]      w_data;
   logic [PKT_W-1:0] pkt_cnt;
   logic [1:0]       w_state;
   logic [STL_W-1:0] stall_cnt;

   w_stream_adapter #(.DATA_SIZE(DW), .PKT_CNT_SIZE(PKT_W), .STALL_CNT_SIZE(STL_W)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .w_full(w_full), .w_en(w_en),
      .w_data(w_data), .pkt_cnt(pkt_cnt), .w_state(w_state), .stall_cnt(stall_cnt)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: words accepted but not yet written, in order
   logic [DW:0]      q[$];
   logic [DW:0]      pend[$];
   logic [PKT_W-1:0] m_pkt;
   logic [STL_W-1:0] m_stall;
   logic             m_ready;
   logic [1:0]       m_state;
   logic             chk_en = 1'b0;
   logic             last_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [STL_W-1:0] stall_exp();
`ifdef W_STALL_CNT_EN
      return m_stall;
`else
      return '0;
`endif
   endfunction

   task automatic step();
      logic       acc, cons, stl;
      logic [DW:0] word, popped;
      if (chk_en) begin
         check("s_ready", s_ready, m_ready);
         check("w_en", w_en, q.size() > 0);
         if (q.size() > 0) check("w_data", w_data, q[0]);
         check("w_state", w_state, m_state);
         check("pkt_cnt", pkt_cnt, m_pkt);
         check("stall_cnt", stall_cnt, stall_exp());
      end
      acc  = s_valid && m_ready;
      cons = (q.size() > 0) && !w_full;
      stl  = (q.size() > 0) && w_full;
      word = {s_last, s_data};
      @(posedge w_clk);
      #1;
      chk_en   = 1'b1;
      last_acc = acc;
      if (w_rst) begin
         q.delete();
         m_pkt    = '0;
         m_stall  = '0;
         m_ready  = 1'b0;
         m_state  = 2'b00;
         last_acc = 1'b0;
      end else begin
         if (cons) begin
            popped = q.pop_front();
            if (popped[DW]) m_pkt = m_pkt + 1'b1;
         end
         if (acc) q.push_back(word);
         if (stl && m_stall != {STL_W{1'b1}}) m_stall = m_stall + 1'b1;
         case (m_state)
            2'b00:   if (q.size() > 0) m_state = 2'b01;
            2'b01:   if (stl) m_state = 2'b10; else if (q.size() == 0) m_state = 2'b00;
            default: if (cons) m_state = (q.size() > 0) ? 2'b01 : 2'b00;
         endcase
         m_ready = q.size() < 2;
      end
   endtask

   // full_mode: 0 low, 1 high, 2 toggle, 3 random
   task automatic drive(input int full_mode, input int valid_pct);
      s_valid = (pend.size() > 0) && ($urandom_range(99) < valid_pct);
      if (s_valid) {s_last, s_data} = pend[0];
      else         {s_last, s_data} = 9'($urandom);
      case (full_mode)
         0:       w_full = 1'b0;
         1:       w_full = 1'b1;
         2:       w_full = ~w_full;
         default: w_full = 1'($urandom_range(1));
      endcase
   endtask

   task automatic run_cycles(input int n, input int full_mode, input int valid_pct);
      for (int i = 0; i < n; i++) begin
         drive(full_mode, valid_pct);
         step();
         if (last_acc) void'(pend.pop_front());
      end
   endtask

   task automatic run_phase(input int full_mode, input int valid_pct, input int budget);
      int n = 0;
      while ((pend.size() > 0 || q.size() > 0) && n < budget) begin
         drive(full_mode, valid_pct);
         step();
         if (last_acc) void'(pend.pop_front());
         n++;
      end
      if (pend.size() > 0 || q.size() > 0) check("drain_timeout", 1, 0);
      s_valid = 1'b0;
   endtask

   task automatic do_reset();
      pend.delete();
      w_rst = 1'b1; s_valid = 1'b0; w_full = 1'b0;
      step();
      step();
      check("rst_ready", s_ready, 0);
      check("rst_wdata", w_data, 0);
      check("rst_wen", w_en, 0);
      w_rst = 1'b0;
      step();
      check("ready_after_rst", s_ready, 1);
   endtask

   initial begin
      w_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; w_full = 1'b0;
      m_pkt = '0; m_stall = '0; m_ready = 1'b0; m_state = 2'b00; last_acc = 1'b0;

      do_reset();
      run_cycles(3, 0, 0);
      check("idle_state", w_state, 2'b00);
      check("idle_pkt", pkt_cnt, 0);

      // 0x01..0x08, one packet, no backpressure
      for (int i = 1; i <= 8; i++) pend.push_back({(i == 8), 8'(i)});
      run_phase(0, 100, 40);
      check("pkt_after_stream", pkt_cnt, 1);

      // stall with three words queued at the producer
      pend.push_back(9'h0A0); pend.push_back(9'h0A1); pend.push_back(9'h0A2);
      run_cycles(6, 1, 100);
      check("stall_ready", s_ready, 0);
      check("stall_wen", w_en, 1);
      check("stall_wdata", w_data, 9'h0A0);
      check("stall_state", w_state, 2'b10);
      check("stall_pending", pend.size(), 1);
      run_phase(0, 100, 40);

      // toggling full, 64 words
      for (int i = 0; i < 64; i++) pend.push_back(9'($urandom));
      run_phase(2, 100, 400);

      // random backpressure and gaps
      for (int i = 0; i < 200; i++) pend.push_back(9'($urandom));
      run_phase(3, 70, 2000);

      // reset with two words buffered
      pend.push_back(9'h1B0); pend.push_back(9'h1B1);
      run_cycles(3, 1, 100);
      check("two_buffered", s_ready, 0);
      pend.delete();
      w_rst = 1'b1; s_valid = 1'b0;
      step();
      check("rst_mid_wen", w_en, 0);
      check("rst_mid_pkt", pkt_cnt, 0);
      w_rst = 1'b0; w_full = 1'b0;
      run_cycles(4, 0, 0);

      // stall counter: one word held against full for 5 edges
      pend.push_back(9'h155);
      run_cycles(6, 1, 100);
`ifdef W_STALL_CNT_EN
      check("stall_cnt_5", stall_cnt, 5);
`else
      check("stall_cnt_tied", stall_cnt, 0);
`endif
      run_phase(0, 100, 20);

      // packet counter wrap: 2^PKT_W + 1 single-word packets
      do_reset();
      for (int i = 0; i < (1 << PKT_W) + 1; i++) pend.push_back({1'b1, 8'($urandom)});
      run_phase(0, 100, 600);
      check("pkt_wrap", pkt_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
